// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter serialising per-core data-memory requests onto one synchronous single-port RAM.
// Latency: request in IDLE at t -> mem_en at t+1 -> req_done/req_rdata at t+3. A core holds its request until done.
module data_mem_arbiter #(
  parameter int NUM_CORES = 16,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [2*NUM_CORES-1:0]      req_ctrl,
  input  logic [ADDR_W*NUM_CORES-1:0] req_addr,
  input  logic [DATA_W*NUM_CORES-1:0] req_wdata,
  output logic [DATA_W*NUM_CORES-1:0] req_rdata,
  output logic [NUM_CORES-1:0]        req_done,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   win;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_vld;
  logic               op_we;
  logic [ADDR_W-1:0]  lat_addr;
  logic [DATA_W-1:0]  lat_wdata;
  logic [NUM_CORES-1:0] req_vec;

  // A core whose done pulse is visible this cycle is still holding its old request.
  always_comb begin
    req_vec = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      req_vec[i] = ((req_ctrl[2*i +: 2] == 2'b01) || (req_ctrl[2*i +: 2] == 2'b10)) && !req_done[i];
    end
  end

  // Scan offsets from highest to lowest so the smallest offset from rr_ptr wins.
  always_comb begin
    int cand;
    cand      = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = NUM_CORES-1; i >= 0; i--) begin
      cand = int'(rr_ptr) + i;
      if (cand >= NUM_CORES) cand = cand - NUM_CORES;
      if (req_vec[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE:   if (grant_vld) state_nxt = ACCESS;
      ACCESS: begin
        mem_en    = 1'b1;
        mem_we    = op_we;
        mem_addr  = lat_addr;
        mem_wdata = lat_wdata;
        state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr    <= '0;
      win       <= '0;
      op_we     <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      req_done  <= '0;
      req_rdata <= '0;
    end else begin
      req_done <= '0;
      case (state)
        IDLE: begin
          if (grant_vld) begin
            win       <= grant_idx;
            op_we     <= (req_ctrl[grant_idx*2 +: 2] == 2'b10);
            lat_addr  <= req_addr[grant_idx*ADDR_W +: ADDR_W];
            lat_wdata <= req_wdata[grant_idx*DATA_W +: DATA_W];
          end
        end
        RESP: begin
          if (!op_we) req_rdata[win*DATA_W +: DATA_W] <= mem_rdata;
          req_done[win] <= 1'b1;
          rr_ptr        <= (win == IDX_W'(NUM_CORES-1)) ? '0 : win + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural synchronous RAM.
module tb_data_mem_arbiter;

  localparam int N  = 16;
  localparam int AW = 16;
  localparam int DW = 16;

  logic            clock = 1'b0;
  logic            reset;
  logic [2*N-1:0]  req_ctrl;
  logic [AW*N-1:0] req_addr;
  logic [DW*N-1:0] req_wdata;
  logic [DW*N-1:0] req_rdata;
  logic [N-1:0]    req_done;
  logic            mem_en, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;

  logic [DW-1:0]   ram [0:255];
  int              n_checks = 0;
  int              n_errors = 0;

  data_mem_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset), .req_ctrl(req_ctrl), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rdata(req_rdata), .req_done(req_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_en && mem_we) ram[mem_addr[7:0]] = mem_wdata;
  end
  always @(posedge clock) begin
    if (mem_en && !mem_we) mem_rdata <= ram[mem_addr[7:0]];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic set_req(input int core, input logic [1:0] c, input logic [15:0] a, input logic [15:0] d);
    req_ctrl[core*2 +: 2]   = c;
    req_addr[core*AW +: AW] = a;
    req_wdata[core*DW +: DW] = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Waits for the core's done pulse and checks the cycle count and one-hot done vector.
  task automatic wait_done(input int core, input int exp_cycles);
    int n;
    logic [N-1:0] onehot;
    n = 0;
    onehot = '0;
    onehot[core] = 1'b1;
    while (n < 12) begin
      tick();
      n++;
      if (req_done[core]) break;
    end
    chk($sformatf("done_lat_c%0d", core), n, exp_cycles);
    chk($sformatf("done_onehot_c%0d", core), req_done, onehot);
  endtask

  int saw_en, saw_done;

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 16'h1000 + 16'(i);
    ram[16] = 16'hBEEF;
    req_ctrl = '0; req_addr = '0; req_wdata = '0;
    do_reset();

    chk("rst_state", dut.state, 0);
    chk("rst_rr_ptr", dut.rr_ptr, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_done", req_done, 0);
    chk("rst_rdata_lo", req_rdata[63:0], 0);
    chk("rst_rdata_hi", req_rdata[255:192], 0);

    // Single read of 0xBEEF by core 0
    set_req(0, 2'b01, 16'h0010, 16'h0);
    tick();
    chk("sr_mem_en", mem_en, 1);
    chk("sr_mem_we", mem_we, 0);
    chk("sr_mem_addr", mem_addr, 16'h0010);
    chk("sr_done_t1", req_done, 0);
    tick();
    chk("sr_mem_en_t2", mem_en, 0);
    chk("sr_done_t2", req_done, 0);
    tick();
    chk("sr_done_t3", req_done, 16'h0001);
    chk("sr_rdata0", req_rdata[0 +: DW], 16'hBEEF);
    set_req(0, 2'b00, 16'h0, 16'h0);

    // Contention 3, 7, 15 from rr_ptr = 0
    do_reset();
    set_req(3, 2'b01, 16'd3, 16'h0);
    set_req(7, 2'b01, 16'd7, 16'h0);
    set_req(15, 2'b01, 16'd15, 16'h0);
    wait_done(3, 3);
    chk("ct_rdata3", req_rdata[3*DW +: DW], 16'h1003);
    set_req(3, 2'b00, 16'h0, 16'h0);
    wait_done(7, 3);
    chk("ct_rdata7", req_rdata[7*DW +: DW], 16'h1007);
    set_req(7, 2'b00, 16'h0, 16'h0);
    wait_done(15, 3);
    chk("ct_rdata15", req_rdata[15*DW +: DW], 16'h100F);
    set_req(15, 2'b00, 16'h0, 16'h0);
    chk("ct_rr_ptr", dut.rr_ptr, 0);

    // All cores requesting continuously: two full rounds, 3 cycles per core
    for (int i = 0; i < N; i++) set_req(i, 2'b01, 16'(i), 16'h0);
    for (int k = 0; k < 2*N; k++) wait_done(k % N, 3);
    req_ctrl = '0;
    chk("fr_rdata5", req_rdata[5*DW +: DW], 16'h1005);
    chk("fr_rdata12", req_rdata[12*DW +: DW], 16'h100C);

    // Write then read back through another core
    tick();
    set_req(5, 2'b10, 16'h00A0, 16'h1234);
    tick();
    chk("wr_mem_en", mem_en, 1);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_addr", mem_addr, 16'h00A0);
    chk("wr_mem_wdata", mem_wdata, 16'h1234);
    tick();
    chk("wr_mem_we_t2", mem_we, 0);
    tick();
    chk("wr_done", req_done, 16'h0020);
    chk("wr_rdata5_kept", req_rdata[5*DW +: DW], 16'h1005);
    set_req(5, 2'b00, 16'h0, 16'h0);
    set_req(9, 2'b01, 16'h00A0, 16'h0);
    wait_done(9, 3);
    chk("rd_rdata9", req_rdata[9*DW +: DW], 16'h1234);
    set_req(9, 2'b00, 16'h0, 16'h0);

    // ctrl = 11 is idle
    set_req(4, 2'b11, 16'h0004, 16'h5555);
    saw_en = 0; saw_done = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (mem_en) saw_en++;
      if (req_done[4]) saw_done++;
    end
    chk("c11_mem_en", saw_en, 0);
    chk("c11_done4", saw_done, 0);
    set_req(4, 2'b00, 16'h0, 16'h0);

    // Reset while core 2's read is in ACCESS
    set_req(2, 2'b01, 16'd2, 16'h0);
    tick();
    chk("ra_in_access", mem_en, 1);
    reset = 1'b1;
    set_req(2, 2'b00, 16'h0, 16'h0);
    tick();
    reset = 1'b0;
    chk("ra_mem_en", mem_en, 0);
    chk("ra_mem_addr", mem_addr, 0);
    chk("ra_done", req_done, 0);
    chk("ra_rdata9", req_rdata[9*DW +: DW], 0);
    chk("ra_rr_ptr", dut.rr_ptr, 0);
    saw_done = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (req_done != '0) saw_done++;
    end
    chk("ra_no_done", saw_done, 0);
    set_req(2, 2'b01, 16'd2, 16'h0);
    wait_done(2, 3);
    chk("ra_rdata2", req_rdata[2*DW +: DW], 16'h1002);
    set_req(2, 2'b00, 16'h0, 16'h0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
